// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fft_pkg
// Purpose  : Shared sequencer state encoding and twiddle ROM bridge latency.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int unsigned TW_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/twiddle_addr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : twiddle_addr_sequencer_if
// Purpose   : Control, ROM-request and bridge-tag signals of the sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
interface twiddle_addr_sequencer_if #(
    parameter int FFT_N = 10
) ();

    localparam int c_stage_w = $clog2(FFT_N);

    logic                 start;
    logic                 stall;
    logic                 busy;
    logic                 done;
    logic                 tact_rom;
    logic [FFT_N-2:0]     ta_rom;
    logic                 evenOdd;
    logic                 tw_valid;
    logic [c_stage_w-1:0] tw_stage;
    logic [FFT_N-2:0]     tw_bfly;

    modport master (
        output start,
        output stall,
        input  busy,
        input  done,
        input  tact_rom,
        input  ta_rom,
        input  evenOdd,
        input  tw_valid,
        input  tw_stage,
        input  tw_bfly
    );

    modport slave (
        input  start,
        input  stall,
        output busy,
        output done,
        output tact_rom,
        output ta_rom,
        output evenOdd,
        output tw_valid,
        output tw_stage,
        output tw_bfly
    );

endinterface
`default_nettype wire

// File: rtl/fft_tag_delay.sv
`default_nettype none
// ============================================================================
// Module   : fft_tag_delay
// Purpose  : Fixed-depth valid/tag shift line matching the ROM bridge latency.
// Revision : 1.0 - initial release
// ============================================================================
module fft_tag_delay #(
    parameter int DEPTH = 3,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][TAG_W-1:0] r_tag;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= '0;
                r_tag   <= '0;
            end else begin
                r_valid <= i_valid;
                r_tag   <= i_tag;
            end
        end
    end else begin : g_chain
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= '0;
                r_tag   <= '0;
            end else begin
                r_valid <= {r_valid[DEPTH-2:0], i_valid};
                r_tag   <= {r_tag[DEPTH-2:0], i_tag};
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_tag   = r_tag[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/twiddle_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_addr_sequencer
// Purpose  : Walks every (stage, butterfly) pair of a radix-2 FFT and issues
//            twiddle ROM indices in the shared-ROM even phase.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_addr_sequencer
    import fft_pkg::*;
#(
    parameter int FFT_N = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    twiddle_addr_sequencer_if.slave  bus
);

    localparam int c_stage_w = $clog2(FFT_N);
    localparam int c_bfly_w  = FFT_N - 1;
    localparam int c_tag_w   = c_stage_w + c_bfly_w;
    localparam int c_dcnt_w  = (TW_LATENCY > 1) ? $clog2(TW_LATENCY) : 1;

    localparam logic [c_stage_w-1:0] c_top_stage  = c_stage_w'(FFT_N - 1);
    localparam logic [c_dcnt_w-1:0]  c_drain_last = c_dcnt_w'(TW_LATENCY - 1);

    seq_state_t           r_state;
    logic [c_stage_w-1:0] r_s;
    logic [c_bfly_w-1:0]  r_b;
    logic                 r_phase;
    logic                 r_busy;
    logic                 r_done;
    logic [c_dcnt_w-1:0]  r_drain_cnt;

    logic                 w_issue;
    logic                 w_b_last;
    logic                 w_s_last;
    logic [c_bfly_w-1:0]  w_mask;
    logic [c_bfly_w-1:0]  w_addr;
    logic [c_stage_w-1:0] w_shamt;
    logic [c_tag_w-1:0]   w_tag_in;
    logic [c_tag_w-1:0]   w_tag_out;
    logic                 w_tw_valid;

    assign w_issue  = (r_state == ST_RUN) && !r_phase && !bus.stall;
    assign w_b_last = &r_b;
    assign w_s_last = (r_s == c_top_stage);

    // k = (b mod 2^s) << (N-1-s): a mask and a barrel shift, no arithmetic
    assign w_mask  = ~({c_bfly_w{1'b1}} << r_s);
    assign w_shamt = c_top_stage - r_s;
    assign w_addr  = (r_b & w_mask) << w_shamt;

    assign w_tag_in = w_issue ? {r_s, r_b} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_b         <= '0;
            r_phase     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_s     <= '0;
                        r_b     <= '0;
                        r_phase <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_phase <= ~r_phase;
                    if (w_issue) begin
                        r_b <= r_b + 1'b1;
                        if (w_b_last) begin
                            if (w_s_last) begin
                                r_state     <= ST_DRAIN;
                                r_phase     <= 1'b0;
                                r_drain_cnt <= '0;
                            end else begin
                                r_s <= r_s + 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last issue surfaces from the bridge in the final DRAIN cycle
                    if (r_drain_cnt == c_drain_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_phase <= 1'b0;
                end
            endcase
        end
    end

    fft_tag_delay #(
        .DEPTH (TW_LATENCY),
        .TAG_W (c_tag_w)
    ) u_tag_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_issue),
        .i_tag   (w_tag_in),
        .o_valid (w_tw_valid),
        .o_tag   (w_tag_out)
    );

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.tact_rom = w_issue;
    assign bus.ta_rom   = w_issue ? w_addr : '0;
    assign bus.evenOdd  = r_phase;
    assign bus.tw_valid = w_tw_valid;
    assign bus.tw_stage = w_tag_out[c_tag_w-1 -: c_stage_w];
    assign bus.tw_bfly  = w_tag_out[c_bfly_w-1:0];

endmodule
`default_nettype wire

// File: tb/tb_twiddle_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_addr_sequencer
// Purpose  : Directed scoreboard bench for FFT_N=3 and FFT_N=10 sequencers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_addr_sequencer;

    typedef struct { int ta; int s; int b; } iss_t;
    typedef struct { int s; int b; int cyc; } br_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    iss_t exp_iss3[$];
    br_t  bridge3[$];
    int   n_issue3      = 0;
    int   n_tw3         = 0;
    int   n_done3       = 0;
    int   last_iss_cyc3 = -1;
    int   iss_base3     = 0;
    int   done_base3    = 0;
    bit   gap_chk3      = 1'b0;

    int n_issue10 = 0;
    int n_done10  = 0;
    int s10       = 0;
    int b10       = 0;
    int last_ta10 = -1;

    twiddle_addr_sequencer_if #(.FFT_N(3))  bus3 ();
    twiddle_addr_sequencer_if #(.FFT_N(10)) bus10 ();

    twiddle_addr_sequencer #(.FFT_N(3)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    twiddle_addr_sequencer #(.FFT_N(10)) dut10 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus10)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int exp_ta(input int n, input int s, input int b);
        return ((b % (1 << s)) << (n - 1 - s)) & ((1 << (n - 1)) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start3();
        exp_iss3.delete();
        for (int s = 0; s < 3; s++)
            for (int b = 0; b < 4; b++)
                exp_iss3.push_back('{ta: exp_ta(3, s, b), s: s, b: b});
        last_iss_cyc3 = -1;
        iss_base3     = n_issue3;
        done_base3    = n_done3;
        bus3.start    = 1'b1;
        step(1);
        bus3.start = 1'b0;
        check("start_busy", 32'(bus3.busy), 1);
        check("start_phase0", 32'(bus3.evenOdd), 0);
        check("start_first_issue", 32'(bus3.tact_rom), 1);
    endtask

    task automatic wait_done3(input int budget);
        int k = 0;
        while (bus3.done !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check("done3_seen", 32'(bus3.done), 1);
    endtask

    task automatic check_all_zero3(input string tag);
        check({tag, "_busy"},     32'(bus3.busy), 0);
        check({tag, "_done"},     32'(bus3.done), 0);
        check({tag, "_tact_rom"}, 32'(bus3.tact_rom), 0);
        check({tag, "_ta_rom"},   32'(bus3.ta_rom), 0);
        check({tag, "_evenOdd"},  32'(bus3.evenOdd), 0);
        check({tag, "_tw_valid"}, 32'(bus3.tw_valid), 0);
        check({tag, "_tw_stage"}, 32'(bus3.tw_stage), 0);
        check({tag, "_tw_bfly"},  32'(bus3.tw_bfly), 0);
    endtask

    // FFT_N=3 scoreboard: issues pop the expected list, bridge entries pop on tw_valid
    always @(negedge clk) begin
        br_t  be;
        iss_t ie;
        if (bus3.tw_valid === 1'b1) begin
            n_tw3++;
            check("tw_expected", 32'(bridge3.size() > 0), 1);
            if (bridge3.size() > 0) begin
                be = bridge3.pop_front();
                check("tw_stage", 32'(bus3.tw_stage), be.s);
                check("tw_bfly", 32'(bus3.tw_bfly), be.b);
                check("tw_latency", cyc - be.cyc, 3);
            end
        end else begin
            check("tw_tags_idle", 32'({bus3.tw_stage, bus3.tw_bfly}), 0);
        end
        if (bus3.tact_rom === 1'b1) begin
            n_issue3++;
            check("iss_phase", 32'(bus3.evenOdd), 0);
            check("iss_stall", 32'(bus3.stall), 0);
            check("iss_expected", 32'(exp_iss3.size() > 0), 1);
            if (exp_iss3.size() > 0) begin
                ie = exp_iss3.pop_front();
                check("ta_rom", 32'(bus3.ta_rom), ie.ta);
                bridge3.push_back('{s: ie.s, b: ie.b, cyc: cyc});
            end
            if (gap_chk3 && last_iss_cyc3 >= 0)
                check("iss_gap", cyc - last_iss_cyc3, 2);
            last_iss_cyc3 = cyc;
        end else begin
            check("ta_idle", 32'(bus3.ta_rom), 0);
        end
        if (bus3.done === 1'b1) begin
            n_done3++;
            check("done_latency", cyc - last_iss_cyc3, 4);
            check("done_tw_drained", bridge3.size(), 0);
        end
    end

    always @(negedge clk) begin
        if (bus10.tact_rom === 1'b1) begin
            check("ta_rom10", 32'(bus10.ta_rom), exp_ta(10, s10, b10));
            last_ta10 = int'(bus10.ta_rom);
            n_issue10++;
            b10++;
            if (b10 == 512) begin
                b10 = 0;
                s10++;
            end
        end
        if (bus10.done === 1'b1) n_done10++;
    end

    initial begin
        int k;
        int tw_snap;
        int dn_snap;
        logic eo;

        bus3.start  = 1'b0;
        bus3.stall  = 1'b0;
        bus10.start = 1'b0;
        bus10.stall = 1'b0;
        reset_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero3("rst");
        check("rst_busy10", 32'(bus10.busy), 0);

        // Run 1: unstalled, 2-cycle issue spacing, start ignored while busy and on done
        reset_n  = 1'b1;
        gap_chk3 = 1'b1;
        do_start3();
        step(3);
        bus3.start = 1'b1;
        step(1);
        bus3.start = 1'b0;
        wait_done3(100);
        bus3.start = 1'b1;
        step(1);
        bus3.start = 1'b0;
        check("start_on_done_ignored", 32'(bus3.busy), 0);
        step(2);
        check("idle_after_run1", 32'(bus3.busy), 0);
        check("run1_issues", n_issue3 - iss_base3, 12);
        check("run1_done_once", n_done3 - done_base3, 1);
        gap_chk3 = 1'b0;

        // Run 2: five stalled cycles in the middle of stage 1
        do_start3();
        k = 0;
        while (n_issue3 - iss_base3 < 6 && k < 50) begin
            step(1);
            k++;
        end
        check("run2_reach_stage1", n_issue3 - iss_base3, 6);
        bus3.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            eo = bus3.evenOdd;
            step(1);
            check("stall_eo_toggle", 32'(bus3.evenOdd), 32'(!eo));
        end
        check("stall_no_issue", n_issue3 - iss_base3, 6);
        bus3.stall = 1'b0;
        wait_done3(100);
        step(1);
        check("run2_issues", n_issue3 - iss_base3, 12);
        check("run2_done_once", n_done3 - done_base3, 1);

        // Run 3: reset asserted during DRAIN
        do_start3();
        k = 0;
        while (exp_iss3.size() > 0 && k < 50) begin
            step(1);
            k++;
        end
        check("run3_all_issued", exp_iss3.size(), 0);
        check("drain_busy", 32'(bus3.busy), 1);
        #2;
        reset_n = 1'b0;
        bridge3.delete();
        #1;
        check_all_zero3("drain_rst");
        tw_snap = n_tw3;
        dn_snap = n_done3;
        step(1);
        reset_n = 1'b1;
        step(8);
        check("post_rst_no_tw", n_tw3 - tw_snap, 0);
        check("post_rst_no_done", n_done3 - dn_snap, 0);
        check("post_rst_idle", 32'(bus3.busy), 0);

        // Run 4: start on the first edge after reset release
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        do_start3();
        wait_done3(100);
        step(1);
        check("run4_issues", n_issue3 - iss_base3, 12);
        check("run4_done_once", n_done3 - done_base3, 1);

        // Run 5: FFT_N=10 full sequence
        s10 = 0;
        b10 = 0;
        bus10.start = 1'b1;
        step(1);
        bus10.start = 1'b0;
        check("start10_busy", 32'(bus10.busy), 1);
        k = 0;
        while (bus10.done !== 1'b1 && k < 12000) begin
            step(1);
            k++;
        end
        check("done10_seen", 32'(bus10.done), 1);
        step(4);
        check("run10_issues", n_issue10, 5120);
        check("run10_last_ta", last_ta10, 511);
        check("run10_done_once", n_done10, 1);
        check("run10_idle", 32'(bus10.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
